// File: rtl/rom_dl_bridge.sv
// rtl/rom_dl_bridge.sv - ioctl ROM download to SDRAM write bridge with word packing and FIFO
// Optional checksum output enabled by defining ROM_DL_CHECKSUM_EN.
module rom_dl_bridge #(
  parameter int          ADDR_W     = 25,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_wtbt,
  output logic              sd_we,
  input  logic              sd_ack,
  output logic              rom_loaded,
  output logic              busy,
  output logic              overflow
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // download edge tracking and completion flags
  logic dl_q, active_q, ended_q, rom_loaded_q;
  logic dl_rise, dl_fall, acc;

  // pending low byte and held high byte (odd byte waiting one cycle for its push slot)
  logic              pend_v_q, pend_v_d, hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d, hold_a_q, hold_a_d;
  logic [7:0]        pend_d_q, pend_d_d, hold_d_q, hold_d_d;

  // single push port into the FIFO
  logic              push_v;
  logic [ADDR_W-1:0] push_a;
  logic [15:0]       push_d;
  logic [1:0]        push_be;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] mem_a  [FIFO_DEPTH];
  logic [15:0]       mem_d  [FIFO_DEPTH];
  logic [1:0]        mem_be [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              empty, full, pop, push_ok, overflow_q;

  // write request FSM and registered SDRAM outputs
  state_t            state_q, state_d;
  logic              sd_we_q, sd_we_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [15:0]       sd_din_q, sd_din_d;
  logic [1:0]        sd_wtbt_q, sd_wtbt_d;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign acc     = ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX);

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = push_v & (~full | pop);

  // Byte packing: decide this cycle's push and the next pending/held byte state.
  // A held byte never coexists with a pending byte, so one push per cycle suffices.
  always_comb begin
    push_v   = 1'b0;
    push_a   = '0;
    push_d   = '0;
    push_be  = '0;
    pend_v_d = pend_v_q;
    pend_a_d = pend_a_q;
    pend_d_d = pend_d_q;
    hold_v_d = 1'b0;
    hold_a_d = hold_a_q;
    hold_d_d = hold_d_q;
    if (hold_v_q) begin
      push_v  = 1'b1;
      push_a  = hold_a_q;
      push_d  = {hold_d_q, 8'h00};
      push_be = 2'b10;
    end
    if (acc) begin
      if (!ioctl_addr[0]) begin
        if (pend_v_q) begin
          push_v  = 1'b1;
          push_a  = pend_a_q;
          push_d  = {8'h00, pend_d_q};
          push_be = 2'b01;
        end
        pend_v_d = 1'b1;
        pend_a_d = ioctl_addr;
        pend_d_d = ioctl_dout;
      end else if (pend_v_q && (ioctl_addr[ADDR_W-1:1] == pend_a_q[ADDR_W-1:1])) begin
        push_v   = 1'b1;
        push_a   = pend_a_q;
        push_d   = {ioctl_dout, pend_d_q};
        push_be  = 2'b11;
        pend_v_d = 1'b0;
      end else begin
        if (pend_v_q) begin
          push_v  = 1'b1;
          push_a  = pend_a_q;
          push_d  = {8'h00, pend_d_q};
          push_be = 2'b01;
        end
        pend_v_d = 1'b0;
        hold_v_d = 1'b1;
        hold_a_d = {ioctl_addr[ADDR_W-1:1], 1'b0};
        hold_d_d = ioctl_dout;
      end
    end else if (dl_fall && pend_v_q) begin
      push_v   = 1'b1;
      push_a   = pend_a_q;
      push_d   = {8'h00, pend_d_q};
      push_be  = 2'b01;
      pend_v_d = 1'b0;
    end
  end

  // Packing state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
      hold_v_q <= 1'b0;
      hold_a_q <= '0;
      hold_d_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_d_q <= pend_d_d;
      hold_v_q <= hold_v_d;
      hold_a_q <= hold_a_d;
      hold_d_q <= hold_d_d;
    end
  end

  // FIFO pointers and sticky overflow (a push into a full FIFO without a pop is dropped).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (dl_rise)                    overflow_q <= 1'b0;
      else if (push_v && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_a[wr_ptr_q[PTR_W-1:0]]  <= push_a;
      mem_d[wr_ptr_q[PTR_W-1:0]]  <= push_d;
      mem_be[wr_ptr_q[PTR_W-1:0]] <= push_be;
    end
  end

  // Write FSM next state: load head in IDLE, hold request until ack, then pop.
  always_comb begin
    state_d   = state_q;
    sd_we_d   = sd_we_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_wtbt_d = sd_wtbt_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          sd_addr_d = mem_a[rd_ptr_q[PTR_W-1:0]];
          sd_din_d  = mem_d[rd_ptr_q[PTR_W-1:0]];
          sd_wtbt_d = mem_be[rd_ptr_q[PTR_W-1:0]];
          sd_we_d   = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          pop     = 1'b1;
          sd_we_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write FSM state and registered SDRAM request outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sd_we_q   <= 1'b0;
      sd_addr_q <= '0;
      sd_din_q  <= '0;
      sd_wtbt_q <= '0;
    end else begin
      state_q   <= state_d;
      sd_we_q   <= sd_we_d;
      sd_addr_q <= sd_addr_d;
      sd_din_q  <= sd_din_d;
      sd_wtbt_q <= sd_wtbt_d;
    end
  end

  // Download tracking; dl_q resets high so a download interrupted by reset never counts as complete.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q         <= 1'b1;
      active_q     <= 1'b0;
      ended_q      <= 1'b0;
      rom_loaded_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise) begin
        active_q <= 1'b1;
        ended_q  <= 1'b0;
      end else if (dl_fall) begin
        active_q <= 1'b0;
        ended_q  <= active_q;
      end
      if (dl_rise)
        rom_loaded_q <= 1'b0;
      else if (ended_q && !pend_v_q && !hold_v_q && empty && (state_q == S_IDLE))
        rom_loaded_q <= 1'b1;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum_q;

  // Running sum of accepted bytes for the current download.
  always_ff @(posedge clk_sys) begin
    if (reset || dl_rise) sum_q <= '0;
    else if (acc)         sum_q <= sum_q + {8'h00, ioctl_dout};
  end

  assign checksum = sum_q;
`else
  // checksum port and accumulator are not built
`endif

  assign sd_we      = sd_we_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign sd_wtbt    = sd_wtbt_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;
  assign busy       = pend_v_q | hold_v_q | ~empty | (state_q == S_REQ);

endmodule

// File: doc/rom_dl_bridge.md
Name: rom_dl_bridge

Overview:
- Sits between data_io (ioctl byte stream, clock_48 domain) and the sdram controller's write port.
- Packs downloaded ROM bytes into 16-bit words with byte enables and buffers them in a small FIFO.
- Issues one SDRAM write per FIFO entry using a request/acknowledge handshake.
- Produces the rom_loaded flag once the download has ended and every byte has been committed; the core reset logic consumes this flag.

Parameters:
- ADDR_W, 25, width of ioctl_addr and sd_addr.
- FIFO_DEPTH, 4, number of word entries; must be a power of 2, minimum 2.
- ROM_INDEX, 0, ioctl_index value that is accepted; all other indices are ignored.

Ports:
- clk_sys  in  1  system clock (clock_48).
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- sd_addr  out  ADDR_W  word-aligned byte address; bit0 is always 0.
- sd_din  out  16  {high byte, low byte}.
- sd_wtbt  out  2  byte enables: bit1 = high lane, bit0 = low lane.
- sd_we  out  1  write request.
- sd_ack  in  1  one-cycle acceptance from the sdram controller.
- rom_loaded  out  1  download complete and drained.
- busy  out  1  pending byte, or FIFO not empty, or write in flight.
- overflow  out  1  sticky; a word was dropped.

Behaviour:
- Reset values: sd_we=0, sd_addr=0, sd_din=0, sd_wtbt=0, rom_loaded=0, busy=0, overflow=0. FIFO is emptied, the pending-byte register is cleared, and the FSM goes to IDLE.
- Byte accept: a byte is accepted when ioctl_download & ioctl_wr & (ioctl_index==ROM_INDEX).
- Packing, using a pending low-byte register (pend_v, pend_a, pend_d):
  - Even address, no pending: store as pending; no push.
  - Even address, pending present: push the pending byte as {8'h00, pend_d} with wtbt=01, then store the new byte as pending.
  - Odd address equal to pend_a+1: push {byte, pend_d} at pend_a with wtbt=11; clear pending.
  - Odd address, no pending or non-adjacent pending: flush the pending byte (if any) with wtbt=01 in this cycle, then push {byte, 8'h00} at addr&~1 with wtbt=10 in the next cycle. The byte is held internally in between; two pushes occur on consecutive cycles.
- Download end: on the falling edge of ioctl_download, any pending byte is pushed with wtbt=01.
- Push timing: the FIFO push occurs in the cycle after the accepted strobe.
- FIFO:
  - A push while full drops the word and sets overflow. Overflow stays set until reset or the next rising edge of ioctl_download.
  - Push and pop in the same cycle while full is legal and is not an overflow.
- Write FSM:
  - IDLE: if the FIFO is non-empty, load sd_addr, sd_din and sd_wtbt from the FIFO head, set sd_we=1, go to REQ.
  - REQ: hold all outputs stable until sd_ack. On sd_ack, pop the FIFO and drop sd_we in the next cycle. If the FIFO still has data, reload and re-assert after one idle cycle; otherwise return to IDLE.
  - sd_we is always low for at least one cycle between requests.
- Latency: for an idle bridge, an odd byte completing a word at strobe cycle N is pushed at N+1 and sd_we rises at N+2.
- rom_loaded:
  - Cleared on a rising edge of ioctl_download.
  - Set when the download has ended, no byte is pending, the FIFO is empty, and the FSM is in IDLE.
  - A download whose index is not ROM_INDEX still clears and then sets rom_loaded.
- Reset mid-download: all in-flight data is discarded and rom_loaded stays 0 until the next complete download.
- Address wrap: no special handling; ADDR_W bits pass through unchanged.

Optional Feature:
- Macro: ROM_DL_CHECKSUM_EN.
- With the macro defined:
  - Adds output checksum [15:0]: a 16-bit wrapping sum of every accepted byte (zero-extended).
  - Cleared on reset and on the rising edge of ioctl_download.
  - Valid whenever rom_loaded=1.
- Without the macro: the port and its logic are absent.

Test Plan:
- Bytes 0x11@0, 0x22@1, sd_ack returned 2 cycles after sd_we -> one write: sd_addr=0, sd_din=0x2211, wtbt=11; sd_we rises 2 cycles after the second strobe; rom_loaded=1 after download falls.
- Bytes 0xAA@4, then download ends -> single write: addr=4, din=0x00AA, wtbt=01.
- Bytes 0x55@7 alone -> write: addr=6, din=0x5500, wtbt=10. Bytes 0x01@2, 0x02@5 -> two writes: (2, 0x0001, 01) then (4, 0x0200, 10).
- 16 bytes at back-to-back strobes with sd_ack held off for 40 cycles, FIFO_DEPTH=4 -> overflow=1; after acks, the first 4 words are written in order.
- Download with ioctl_index=1, ROM_INDEX=0 -> no sd_we ever; rom_loaded 1→0→1.
- reset asserted while the FSM is in REQ -> next cycle sd_we=0, busy=0, rom_loaded=0. With ROM_DL_CHECKSUM_EN and bytes 0xFF,0x02 -> checksum=0x0101.
